pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Program-counter register and hardware return-address stack for the pipelined core. It consumes the per-cycle PC-source selects and push/pop requests from the jump controller and computes the next PC. It holds the PC for the fetch stage and the return addresses for JSB/return flow. It sits between the jump controller (decode stage) and instruction fetch.

## Interface
Parameters:
- PC_WIDTH, 12, width of PC, jump constants and stack entries
- OFFSET_WIDTH, 8, width of the signed branch offset
- DEPTH, 8, number of stack entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard hold; freezes PC and stack for this cycle
- sel_PC_src_plus1  input  1  next PC = pc + 1
- sel_PC_src_offset  input  1  next PC = id_pc_plus1 + sext(branch_offset)
- sel_PC_src_const  input  1  next PC = jump_const
- sel_PC_src_stack  input  1  next PC = stack_top
- push_stack  input  1  push id_pc_plus1 (JSB return address)
- pop_stack  input  1  pop top entry (return)
- id_pc_plus1  input  PC_WIDTH  PC+1 of the instruction in decode
- branch_offset  input  OFFSET_WIDTH  two's-complement branch offset
- jump_const  input  PC_WIDTH  absolute jump target
- pc  output  PC_WIDTH  current fetch PC (registered)
- pc_plus1  output  PC_WIDTH  pc + 1, mod 2^PC_WIDTH (combinational)
- stack_top  output  PC_WIDTH  entry at sp-1; 0 when empty
- stack_empty  output  1  sp == 0
- stack_full  output  1  sp == DEPTH
- stack_error  output  1  sticky: overflow or underflow has occurred

## Operation
- State: pc register, stack array of DEPTH entries, pointer sp (0..DEPTH, clog2(DEPTH)+1 bits), and a sticky error bit.
- Next-PC select priority: stack > const > offset > plus1. The selects are normally one-hot. If none is asserted, the unit behaves as plus1.
- Offset arithmetic: branch_offset is sign-extended to PC_WIDTH and added to id_pc_plus1. The result wraps modulo 2^PC_WIDTH.
- pc+1 wraps: 2^PC_WIDTH-1 → 0.
- Push only (not full): stack[sp] ← id_pc_plus1, sp ← sp+1.
- Push when full: the push is dropped, entries and sp are unchanged, stack_error ← 1. PC still follows the select.
- Pop only (not empty): sp ← sp-1. The redirect uses the pre-pop stack_top.
- Pop when empty: sp stays 0, stack_error ← 1, and the redirect target is 0.
- Push and pop in the same cycle: the top entry is replaced. stack[sp-1] ← id_pc_plus1 and sp is unchanged. If the stack is empty, this acts as a plain push with no error. The stack-select target is the old top, or 0 if empty.
- stall=1: pc, stack entries, sp and error all hold. Selects, push and pop are ignored that cycle.
- stack_error clears only on rst.
- Reset (async, rst=1): pc=0, sp=0, all entries 0, stack_error=0. Resulting outputs: pc=0, pc_plus1=1, stack_top=0, stack_empty=1, stack_full=0, stack_error=0. State is held while rst is high.
- Reset during a push/pop cycle: reset wins, and no partial update is permitted.

## Timing
- pc, sp, entries and stack_error update on the rising edge after the cycle in which the selects are presented. Latency is 1 cycle.
- stack_top, stack_empty, stack_full and pc_plus1 are combinational from registered state.
- A pushed value appears on stack_top in the cycle after the push edge.
- Back-to-back push/pop on consecutive cycles is fully supported, with no bubble.
- rst deassertion: the first update occurs on the first rising edge with rst=0.
- No combinational path from push_stack/pop_stack to stack_top. stack_top reflects the pre-edge state within a cycle.

## Test plan
- Reset then free-run with sel_PC_src_plus1=1 for 5 cycles → pc goes 0,1,2,3,4,5. stack_empty=1, stack_error=0.
- Branch: pc=0x010, id_pc_plus1=0x010, branch_offset=0xFC (-4), sel_PC_src_offset=1 → next pc=0x00C. With offset 0x05 from 0xFFE → pc=0x003 (wrap).
- JSB/return: push_stack=1 and sel_PC_src_const=1 with id_pc_plus1=0x021, jump_const=0x300 → pc=0x300, stack_top=0x021. Then pop_stack=1 and sel_PC_src_stack=1 → pc=0x021, stack_empty=1.
- Overflow: push 0x001..0x008 → stack_full=1, stack_top=0x008. A 9th push of 0x009 → stack_top=0x008, sp unchanged, stack_error=1 until rst.
- Underflow/combined: pop on empty → pc=0, stack_error=1. Then, with top=0x055, push 0x077 and pop in the same cycle → stack_top=0x077, sp unchanged, pc=0x055.
- Stall and async reset: stall=1 with sel_PC_src_const=1 and push_stack=1 → pc, stack and flags unchanged. Then assert rst mid-cycle → pc=0, stack_empty=1 and stack_error=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter register with hardware return-address stack
module pc_stack_unit #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 8,
  parameter int DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    sel_PC_src_plus1,
  input  logic                    sel_PC_src_offset,
  input  logic                    sel_PC_src_const,
  input  logic                    sel_PC_src_stack,
  input  logic                    push_stack,
  input  logic                    pop_stack,
  input  logic [PC_WIDTH-1:0]     id_pc_plus1,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0]     jump_const,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [PC_WIDTH-1:0]     pc_plus1,
  output logic [PC_WIDTH-1:0]     stack_top,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    stack_error
);
  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  logic [PC_WIDTH-1:0]             pc_q, pc_d, off_target;
  logic [DEPTH-1:0][PC_WIDTH-1:0]  stack_q, stack_d;
  logic [SPW-1:0]                  sp_q, sp_d;
  logic                            err_q, err_d;
  logic [IW-1:0]                   top_idx;
  assign pc          = pc_q;
  assign pc_plus1    = pc_q + PC_WIDTH'(1);
  assign stack_empty = sp_q == '0;
  assign stack_full  = sp_q == SPW'(DEPTH);
  assign stack_error = err_q;
  assign top_idx     = IW'(sp_q - SPW'(1));
  assign stack_top   = stack_empty ? '0 : stack_q[top_idx];
  assign off_target  = id_pc_plus1 + PC_WIDTH'($signed(branch_offset));
  always_comb begin
    pc_d    = pc_q;
    stack_d = stack_q;
    sp_d    = sp_q;
    err_d   = err_q;
    if (!stall) begin
      pc_d = sel_PC_src_stack  ? stack_top :
             sel_PC_src_const  ? jump_const :
             sel_PC_src_offset ? off_target : pc_plus1;
      if (push_stack && pop_stack && !stack_empty) stack_d[top_idx] = id_pc_plus1;
      else if (push_stack && stack_full) err_d = 1'b1;
      else if (push_stack) begin
        stack_d[sp_q[IW-1:0]] = id_pc_plus1;
        sp_d = sp_q + SPW'(1);
      end
      else if (pop_stack && stack_empty) err_d = 1'b1;
      else if (pop_stack) sp_d = sp_q - SPW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      stack_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed scoreboard bench for pc_stack_unit
module tb_pc_stack_unit;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        s_plus1 = 1'b0, s_off = 1'b0, s_const = 1'b0, s_stack = 1'b0;
  logic        push = 1'b0, pop = 1'b0;
  logic [11:0] idp = '0, jc = '0;
  logic [7:0]  off = '0;
  logic [11:0] pc, pc_plus1, stack_top;
  logic        stack_empty, stack_full, stack_error;
  int          tests = 0, fails = 0;
  typedef struct {logic [11:0] pc, top; logic empty, full, err;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  pc_stack_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .sel_PC_src_plus1(s_plus1), .sel_PC_src_offset(s_off),
    .sel_PC_src_const(s_const), .sel_PC_src_stack(s_stack),
    .push_stack(push), .pop_stack(pop),
    .id_pc_plus1(idp), .branch_offset(off), .jump_const(jc),
    .pc(pc), .pc_plus1(pc_plus1), .stack_top(stack_top),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_error(stack_error)
  );
  function automatic exp_t mk(logic [11:0] p, logic [11:0] t, logic e, logic f, logic r);
    exp_t x;
    x.pc = p; x.top = t; x.empty = e; x.full = f; x.err = r;
    return x;
  endfunction
  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag, exp_t e);
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".pc_plus1"}, pc_plus1, e.pc + 12'd1);
    chk({tag, ".top"}, stack_top, e.top);
    chk({tag, ".empty"}, {11'd0, stack_empty}, {11'd0, e.empty});
    chk({tag, ".full"}, {11'd0, stack_full}, {11'd0, e.full});
    chk({tag, ".err"}, {11'd0, stack_error}, {11'd0, e.err});
  endtask
  // sel = {stack, const, offset, plus1}
  task automatic step(string tag, logic [3:0] sel, logic ps, logic pp, logic st,
                      logic [11:0] i, logic [7:0] o, logic [11:0] j, exp_t e);
    {s_stack, s_const, s_off, s_plus1} = sel;
    push = ps; pop = pp; stall = st; idp = i; off = o; jc = j;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else check_all(tag, sb.pop_front());
  endtask
  initial begin
    #12;
    check_all("reset", mk(12'h000, 12'h000, 1, 0, 0));
    rst = 1'b0;
    for (int k = 1; k <= 5; k++)
      step("run", 4'b0001, 0, 0, 0, 0, 0, 0, mk(12'(k), 0, 1, 0, 0));
    step("jmp010", 4'b0100, 0, 0, 0, 0, 0, 12'h010, mk(12'h010, 0, 1, 0, 0));
    step("br_neg", 4'b0010, 0, 0, 0, 12'h010, 8'hFC, 0, mk(12'h00C, 0, 1, 0, 0));
    step("br_wrap", 4'b0010, 0, 0, 0, 12'hFFE, 8'h05, 0, mk(12'h003, 0, 1, 0, 0));
    step("jmpFFF", 4'b0100, 0, 0, 0, 0, 0, 12'hFFF, mk(12'hFFF, 0, 1, 0, 0));
    step("pc_wrap", 4'b0001, 0, 0, 0, 0, 0, 0, mk(12'h000, 0, 1, 0, 0));
    step("jsb", 4'b0100, 1, 0, 0, 12'h021, 0, 12'h300, mk(12'h300, 12'h021, 0, 0, 0));
    step("ret", 4'b1000, 0, 1, 0, 0, 0, 0, mk(12'h021, 0, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      step("fill", 4'b0001, 1, 0, 0, 12'(k), 0, 0, mk(12'h021 + 12'(k), 12'(k), 0, k == 8, 0));
    step("ovf", 4'b0001, 1, 0, 0, 12'h009, 0, 0, mk(12'h02A, 12'h008, 0, 1, 1));
    step("pop_after_ovf", 4'b1000, 0, 1, 0, 0, 0, 0, mk(12'h008, 12'h007, 0, 0, 1));
    rst = 1'b1;
    #2;
    check_all("rst_mid", mk(0, 0, 1, 0, 0));
    rst = 1'b0;
    step("run2a", 4'b0001, 0, 0, 0, 0, 0, 0, mk(12'h001, 0, 1, 0, 0));
    step("run2b", 4'b0001, 0, 0, 0, 0, 0, 0, mk(12'h002, 0, 1, 0, 0));
    step("udf", 4'b1000, 0, 1, 0, 0, 0, 0, mk(12'h000, 0, 1, 0, 1));
    step("push55", 4'b0001, 1, 0, 0, 12'h055, 0, 0, mk(12'h001, 12'h055, 0, 0, 1));
    step("pushpop", 4'b1000, 1, 1, 0, 12'h077, 0, 0, mk(12'h055, 12'h077, 0, 0, 1));
    step("pop77", 4'b0001, 0, 1, 0, 0, 0, 0, mk(12'h056, 0, 1, 0, 1));
    step("pushC3", 4'b0001, 1, 0, 0, 12'h0C3, 0, 0, mk(12'h057, 12'h0C3, 0, 0, 1));
    step("stall_push", 4'b0100, 1, 0, 1, 12'h456, 0, 12'h123, mk(12'h057, 12'h0C3, 0, 0, 1));
    step("stall_pop", 4'b1000, 0, 1, 1, 0, 0, 0, mk(12'h057, 12'h0C3, 0, 0, 1));
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", mk(0, 0, 1, 0, 0));
    step("rst_hold", 4'b0100, 1, 0, 0, 12'h111, 0, 12'h123, mk(0, 0, 1, 0, 0));
    rst = 1'b0;
    step("pushpop_empty", 4'b0001, 1, 1, 0, 12'h0AA, 0, 0, mk(12'h001, 12'h0AA, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
